bme280_sequencer: RTL and testbench
===================================

// Module: bme280_sequencer
// PURPOSE
//  Master controller for the i2c register-interface block. It drives that block's address/write_data/we/re bus.
//  On each start it runs one BME280 measurement: writes ctrl_meas, waits for conversion, then reads the six raw bytes 0xF7..0xFC.
//  Results are packed into 20-bit raw pressure/temperature words with a one-cycle valid pulse. Sits between top-level control and i2c.
// PARAMETERS
//  SLAVE_ADDR   7'h76  BME280 7-bit device address
//  CTRL_MEAS    8'h27  value written to register 0xF4 (osrs_t=1, osrs_p=1, normal mode)
//  BURST_BASE   8'hF7  first data register read
//  XFER_CYCLES  4      clocks enable is held high per transaction (>=1)
//  MEAS_WAIT    8      clocks idle between config write and first read (>=1)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous active-high reset
//  start          in   1   begin one measurement; sampled only in IDLE
//  busy           out  1   high from cycle after start accepted until DONE exits
//  done           out  1   one-cycle pulse; raw_* valid from this cycle
//  i2c_address    out  3   register select to i2c (0 EN,1 SLV,2 RW,3 REG,4 DIN,5 DOUT)
//  i2c_write_data out  8   write data to i2c
//  i2c_we         out  1   write strobe to i2c
//  i2c_re         out  1   read strobe to i2c
//  i2c_read_data  in   8   read data from i2c
//  raw_press      out  20  {F7,F8,F9[7:4]}
//  raw_temp       out  20  {FA,FB,FC[7:4]}
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, i2c_we, i2c_re=0; i2c_address, i2c_write_data, raw_*, byte buffer=0.
//  All outputs registered. One i2c bus access per clock; we and re never high together.
//  Read/write encoding on RW reg: 0=write, 1=read.
//  Write transaction, one clock each unless noted: SLV(we,data={0,SLAVE_ADDR}); RW(we,0); REG(we,0xF4); DAT(we,CTRL_MEAS); EN_ON(we,addr 0,data 1).
//   Then WAIT (we=0, XFER_CYCLES clocks), then EN_OFF(we,data 0). Total 6+XFER_CYCLES clocks.
//  Read transaction k=0..5: SLV; RW(data 1); REG(BURST_BASE+k); EN_ON; WAIT; EN_OFF; then RD_REQ(re,addr 5); then RD_CAP.
//   RD_CAP stores i2c_read_data into byte[k]. Total 7+XFER_CYCLES clocks.
//  Top sequence: IDLE -start-> write txn -> MEAS_DLY (MEAS_WAIT clocks) -> read txn k=0..5 -> DONE -> IDLE.
//  DONE (1 clock): load raw_press/raw_temp from byte buffer, pulse done, busy drops next cycle.
//  Latency: start sampled at edge 0 -> done high exactly (6+X)+M+6*(7+X)+1 clocks later (X=XFER_CYCLES, M=MEAS_WAIT).
//  start while busy or in DONE: ignored, no queuing. start held high in IDLE after DONE: new run begins.
//  Single down-counter shared by WAIT and MEAS_DLY, width clog2(max(X,M))+1; loaded on entry, exits on count==1.
//  Byte index k 3-bit; register address is BURST_BASE+k in 8-bit arithmetic (wraps, no saturation).
//  raw_* hold last result until next DONE; not cleared by start.
//  Reset mid-transaction: no EN_OFF is issued (i2c shares rst and clears enable itself); next start begins cleanly at SLV.
// STRUCTURE
//  Package bme280_seq_pkg: i2c register-select localparams (REG_ENABLE..REG_DATA_OUT), BME280 register constants (0xF4, 0xF7), state encoding.
//  Single module, no sub-modules. State machine plus one wait counter, 3-bit byte index, phase flag (write/read), 6x8 byte buffer.
// TESTING (X=4, M=8 -> done at clock 85)
//  Reset mid-WAIT of read k=2 -> all outputs 0 next edge. Then start -> full run, first access SLV with data 0x76.
//  Start in IDLE; trace bus. Expect we at addr 1,2,3,4,0 with data 76,00,F4,27,01, 4 idle clocks, we addr0 data00.
//   Then 8 idle clocks, then first read REG=F7; done at clock 85.
//  Model returns F7..FC = 0x65,0x5A,0xC0,0x7E,0xED,0x00.
//   Expect raw_press=0x655AC, raw_temp=0x7EED0, done 1 cycle, busy 0 the cycle after.
//  Pulse start at clocks 3 and 50 of a run -> ignored; exactly one done; bus trace identical to single start.
//  Hold start high continuously -> back-to-back runs, IDLE occupied exactly 1 clock between DONE and next SLV.
//  Assertions throughout: never we&&re; re only with i2c_address==5; enable written 1 always followed by enable written 0 unless reset.

Source files
------------

// File: rtl/bme280_seq_pkg.sv
// Shared constants and state encoding for the BME280 measurement sequencer.
package bme280_seq_pkg;

  // Register selects of the i2c register-interface block
  localparam logic [2:0] REG_ENABLE   = 3'd0;
  localparam logic [2:0] REG_SLAVE    = 3'd1;
  localparam logic [2:0] REG_RW       = 3'd2;
  localparam logic [2:0] REG_REG      = 3'd3;
  localparam logic [2:0] REG_DATA_IN  = 3'd4;
  localparam logic [2:0] REG_DATA_OUT = 3'd5;

  // BME280 register map
  localparam logic [7:0] BME_CTRL_MEAS_REG = 8'hF4;
  localparam logic [7:0] BME_DATA_BASE     = 8'hF7;
  localparam int         NUM_BYTES         = 6;

  // state       | meaning
  // ST_IDLE     | waiting for start
  // ST_SLV      | write device address to SLV
  // ST_RW       | write direction (0 write, 1 read) to RW
  // ST_REG      | write target register address to REG
  // ST_DAT      | write ctrl_meas value to DIN (write phase only)
  // ST_EN_ON    | write 1 to EN, kicks off the bus transfer
  // ST_WAIT     | transfer in flight, bus idle for XFER_CYCLES clocks
  // ST_EN_OFF   | write 0 to EN
  // ST_MEAS_DLY | conversion wait, MEAS_WAIT clocks
  // ST_RD_REQ   | read strobe on DOUT
  // ST_RD_CAP   | capture read data into byte buffer
  // ST_DONE     | publish raw words, pulse done
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SLV,
    ST_RW,
    ST_REG,
    ST_DAT,
    ST_EN_ON,
    ST_WAIT,
    ST_EN_OFF,
    ST_MEAS_DLY,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/bme280_sequencer.sv
// BME280 measurement sequencer: configures ctrl_meas over the i2c register
// block, waits for conversion, burst-reads 0xF7..0xFC one byte per
// transaction and packs raw 20-bit pressure/temperature words.
// Bus outputs are registered from the current state, so every access
// appears on the bus one clock after the state that issues it.
module bme280_sequencer
  import bme280_seq_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h76,
  parameter logic [7:0] CTRL_MEAS   = 8'h27,
  parameter logic [7:0] BURST_BASE  = BME_DATA_BASE,
  parameter int         XFER_CYCLES = 4,
  parameter int         MEAS_WAIT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [2:0]  i2c_address,
  output logic [7:0]  i2c_write_data,
  output logic        i2c_we,
  output logic        i2c_re,
  input  logic [7:0]  i2c_read_data,
  output logic [19:0] raw_press,
  output logic [19:0] raw_temp
);

  localparam int CNT_MAX = (XFER_CYCLES > MEAS_WAIT) ? XFER_CYCLES : MEAS_WAIT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] CNT_XFER = CW'(XFER_CYCLES);
  localparam logic [CW-1:0] CNT_MEAS = CW'(MEAS_WAIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    K_LAST   = 3'(NUM_BYTES - 1);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_k;
  logic          r_rd_phase;
  logic [7:0]    r_buf [NUM_BYTES];

  logic          w_cnt_last;
  logic          w_we;
  logic          w_re;
  logic [2:0]    w_addr;
  logic [7:0]    w_wdata;
  logic          w_done;

  assign w_cnt_last = (r_cnt == CNT_ONE);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_SLV;
      ST_SLV:      w_next = ST_RW;
      ST_RW:       w_next = ST_REG;
      ST_REG:      w_next = r_rd_phase ? ST_EN_ON : ST_DAT;
      ST_DAT:      w_next = ST_EN_ON;
      ST_EN_ON:    w_next = ST_WAIT;
      ST_WAIT:     if (w_cnt_last) w_next = ST_EN_OFF;
      ST_EN_OFF:   w_next = r_rd_phase ? ST_RD_REQ : ST_MEAS_DLY;
      ST_MEAS_DLY: if (w_cnt_last) w_next = ST_SLV;
      ST_RD_REQ:   w_next = ST_RD_CAP;
      ST_RD_CAP:   w_next = (r_k == K_LAST) ? ST_DONE : ST_SLV;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Shared wait counter, loaded on entry to WAIT / MEAS_DLY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_EN_ON) begin
      r_cnt <= CNT_XFER;
    end else if (r_state == ST_EN_OFF && !r_rd_phase) begin
      r_cnt <= CNT_MEAS;
    end else if (r_state == ST_WAIT || r_state == ST_MEAS_DLY) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Phase flag and byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_phase <= 1'b0;
      r_k        <= 3'd0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_rd_phase <= 1'b0;
        r_k        <= 3'd0;
      end else if (r_state == ST_MEAS_DLY && w_cnt_last) begin
        r_rd_phase <= 1'b1;
      end else if (r_state == ST_RD_CAP && r_k != K_LAST) begin
        r_k <= r_k + 3'd1;
      end
    end
  end

  // Byte capture; the read strobe is on the bus during RD_CAP, so data is taken here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BYTES; i++) r_buf[i] <= 8'h00;
    end else if (r_state == ST_RD_CAP) begin
      r_buf[r_k] <= i2c_read_data;
    end
  end

  // Bus access decode for the current state
  always_comb begin
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_addr  = 3'd0;
    w_wdata = 8'h00;
    w_done  = 1'b0;
    case (r_state)
      ST_SLV: begin
        w_we    = 1'b1;
        w_addr  = REG_SLAVE;
        w_wdata = {1'b0, SLAVE_ADDR};
      end
      ST_RW: begin
        w_we    = 1'b1;
        w_addr  = REG_RW;
        w_wdata = {7'd0, r_rd_phase};
      end
      ST_REG: begin
        w_we    = 1'b1;
        w_addr  = REG_REG;
        w_wdata = r_rd_phase ? (BURST_BASE + {5'd0, r_k}) : BME_CTRL_MEAS_REG;
      end
      ST_DAT: begin
        w_we    = 1'b1;
        w_addr  = REG_DATA_IN;
        w_wdata = CTRL_MEAS;
      end
      ST_EN_ON: begin
        w_we    = 1'b1;
        w_addr  = REG_ENABLE;
        w_wdata = 8'h01;
      end
      ST_EN_OFF: begin
        w_we    = 1'b1;
        w_addr  = REG_ENABLE;
        w_wdata = 8'h00;
      end
      ST_RD_REQ: begin
        w_re    = 1'b1;
        w_addr  = REG_DATA_OUT;
      end
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs and result words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      i2c_we         <= 1'b0;
      i2c_re         <= 1'b0;
      i2c_address    <= 3'd0;
      i2c_write_data <= 8'h00;
      raw_press      <= 20'd0;
      raw_temp       <= 20'd0;
    end else begin
      busy           <= (r_state != ST_IDLE);
      done           <= w_done;
      i2c_we         <= w_we;
      i2c_re         <= w_re;
      i2c_address    <= w_addr;
      i2c_write_data <= w_wdata;
      if (r_state == ST_DONE) begin
        raw_press <= {r_buf[0], r_buf[1], r_buf[2][7:4]};
        raw_temp  <= {r_buf[3], r_buf[4], r_buf[5][7:4]};
      end
    end
  end

endmodule

// File: tb/tb_bme280_sequencer.sv
// Directed bench for bme280_sequencer (XFER_CYCLES=4, MEAS_WAIT=8).
module tb_bme280_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [2:0]  i2c_address;
  logic [7:0]  i2c_write_data;
  logic        i2c_we;
  logic        i2c_re;
  logic [7:0]  i2c_read_data;
  logic [19:0] raw_press;
  logic [19:0] raw_temp;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [6];
  logic [7:0] r_sel;
  logic       en_pend;

  bme280_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .i2c_address    (i2c_address),
    .i2c_write_data (i2c_write_data),
    .i2c_we         (i2c_we),
    .i2c_re         (i2c_re),
    .i2c_read_data  (i2c_read_data),
    .raw_press      (raw_press),
    .raw_temp       (raw_temp)
  );

  always #5 clk = ~clk;

  // i2c block model: remembers the last register address written, returns that byte
  always @(posedge clk or posedge rst) begin
    if (rst) r_sel <= 8'h00;
    else if (i2c_we && i2c_address == 3'd3) r_sel <= i2c_write_data;
  end

  always_comb begin
    int idx;
    idx = int'(r_sel) - 32'hF7;
    i2c_read_data = 8'h00;
    if (idx >= 0 && idx < 6) i2c_read_data = mem[idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus protocol checks on every cycle outside reset
  always @(negedge clk) begin
    if (rst) begin
      en_pend = 1'b0;
    end else begin
      chk("we_re_excl", {31'd0, i2c_we & i2c_re}, 32'd0);
      if (i2c_re) chk("re_addr", {29'd0, i2c_address}, 32'd5);
      if (i2c_we && i2c_address == 3'd0) begin
        if (i2c_write_data == 8'h01) begin
          chk("en_on_unpaired", {31'd0, en_pend}, 32'd0);
          en_pend = 1'b1;
        end else begin
          chk("en_off_unpaired", {31'd0, en_pend}, 32'd1);
          en_pend = 1'b0;
        end
      end
    end
  end

  // Expected {we,re,addr,data,busy,done} in the cycle after edge m (start sampled at edge 0)
  function automatic logic [14:0] exp_bus(input int m);
    logic       we;
    logic       re;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] base;
    int         k;
    int         o;
    we = 1'b0; re = 1'b0; a = 3'd0; d = 8'h00; base = 8'hF7;
    case (m)
      1:  begin we = 1'b1; a = 3'd1; d = 8'h76; end
      2:  begin we = 1'b1; a = 3'd2; d = 8'h00; end
      3:  begin we = 1'b1; a = 3'd3; d = 8'hF4; end
      4:  begin we = 1'b1; a = 3'd4; d = 8'h27; end
      5:  begin we = 1'b1; a = 3'd0; d = 8'h01; end
      10: begin we = 1'b1; a = 3'd0; d = 8'h00; end
      default: begin
        if (m >= 19 && m <= 84) begin
          k = (m - 19) / 11;
          o = (m - 19) % 11;
          case (o)
            0: begin we = 1'b1; a = 3'd1; d = 8'h76; end
            1: begin we = 1'b1; a = 3'd2; d = 8'h01; end
            2: begin we = 1'b1; a = 3'd3; d = base + 8'(k); end
            3: begin we = 1'b1; a = 3'd0; d = 8'h01; end
            8: begin we = 1'b1; a = 3'd0; d = 8'h00; end
            9: begin re = 1'b1; a = 3'd5; end
            default: ;
          endcase
        end
      end
    endcase
    return {we, re, a, d, (m >= 1 && m <= 85), (m == 85)};
  endfunction

  // Called at a negedge; start is sampled at the following posedge (edge 0).
  // p0..p2 are extra edges at which start is pulsed; hold keeps start high
  // through the second back-to-back run.
  task automatic do_run(input bit hold, input int p0, input int p1, input int p2,
                        input int ncyc, input logic [19:0] ep, input logic [19:0] et,
                        input logic [19:0] pp, input logic [19:0] pt);
    start = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      int m;
      @(negedge clk);
      m = (hold && n >= 86) ? n - 86 : n;
      chk($sformatf("bus@%0d", n),
          {17'd0, i2c_we, i2c_re, i2c_address, i2c_write_data, busy, done},
          {17'd0, exp_bus(m)});
      if (m == 85) begin
        chk("raw_press", {12'd0, raw_press}, {12'd0, ep});
        chk("raw_temp",  {12'd0, raw_temp},  {12'd0, et});
      end
      if (m == 50) begin
        chk("raw_press_hold", {12'd0, raw_press}, {12'd0, pp});
        chk("raw_temp_hold",  {12'd0, raw_temp},  {12'd0, pt});
      end
      start = (hold && (n + 1) < 172) || (n + 1) == p0 || (n + 1) == p1 || (n + 1) == p2;
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus"}, {17'd0, i2c_we, i2c_re, i2c_address, i2c_write_data, busy, done}, 32'd0);
    chk({tag, "_press"}, {12'd0, raw_press}, 32'd0);
    chk({tag, "_temp"},  {12'd0, raw_temp},  32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mem[0] = 8'h65; mem[1] = 8'h5A; mem[2] = 8'hC0;
    mem[3] = 8'h7E; mem[4] = 8'hED; mem[5] = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // Single run with the reference data
    do_run(1'b0, -1, -1, -1, 90, 20'h655AC, 20'h7EED0, 20'h00000, 20'h00000);

    // Start pulses while busy and in DONE are ignored; identical trace, one done
    do_run(1'b0, 3, 50, 85, 92, 20'h655AC, 20'h7EED0, 20'h655AC, 20'h7EED0);

    // Reset in the WAIT of read k=2
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
    do_run(1'b0, -1, -1, -1, 46, 20'h0, 20'h0, 20'h0, 20'h0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_edge");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean run after reset; raw words stay 0 until DONE
    do_run(1'b0, -1, -1, -1, 88, 20'h12345, 20'h789AB, 20'h00000, 20'h00000);

    // Start held high: back-to-back runs separated by one IDLE clock
    do_run(1'b1, -1, -1, -1, 176, 20'h12345, 20'h789AB, 20'h12345, 20'h789AB);

    @(negedge clk);
    chk("en_pending_end", {31'd0, en_pend}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
